// File: rtl/autobaud_det.sv
// Measures the bit period of a 0x55 calibration character on rx_i and
// converts it into the modulo value that drives baud_gen.
module autobaud_det #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MIN_SEG = 8,
  parameter int unsigned TIMEOUT = 2**24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  input  logic             arm_i,
  output logic [WIDTH-1:0] baud_modulo_o,
  output logic             valid_o,
  output logic             done_o,
  output logic             err_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_WAIT_FALL,
    S_MEASURE,
    S_REPORT
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_rxS;
  logic             r_rxD;
  logic [WIDTH-1:0] r_tot;
  logic [WIDTH-1:0] r_seg;
  logic [2:0]       r_nfall;
  logic [WIDTH-1:0] r_modulo;
  logic             r_valid;
  logic             r_done;
  logic             r_err;
  logic             r_busy;
  logic             w_fall;
  logic             w_edge;

  assign w_fall = r_rxD & ~r_rxS;
  assign w_edge = r_rxD ^ r_rxS;

  // Synchronizer resets to the idle-high line level so reset never looks like a fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_rxS   <= 1'b1;
      r_rxD   <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_rxS   <= r_sync1;
      r_rxD   <= r_rxS;
    end
  end

  // S_REPORT keeps the FSM busy during the done/err pulse cycle, so an arm
  // arriving alongside the pulse is ignored and busy drops one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_tot    <= '0;
      r_seg    <= '0;
      r_nfall  <= '0;
      r_modulo <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (arm_i) begin
            r_state <= S_WAIT_IDLE;
            r_valid <= 1'b0;
            r_seg   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (!r_rxS) begin
            r_seg <= '0;
          end else if (r_seg == WIDTH'(MIN_SEG - 1)) begin
            r_state <= S_WAIT_FALL;
          end else begin
            r_seg <= r_seg + 1'b1;
          end
        end
        S_WAIT_FALL: begin
          if (w_fall) begin
            r_state <= S_MEASURE;
            r_tot   <= WIDTH'(1);
            r_seg   <= WIDTH'(1);
            r_nfall <= '0;
          end
        end
        S_MEASURE: begin
          r_tot <= r_tot + 1'b1;
          r_seg <= w_edge ? WIDTH'(1) : r_seg + 1'b1;
          if (w_edge && (r_seg < WIDTH'(MIN_SEG))) begin
            r_err   <= 1'b1;
            r_state <= S_REPORT;
          end else if (r_tot == WIDTH'(TIMEOUT)) begin
            r_err   <= 1'b1;
            r_state <= S_REPORT;
          end else if (w_fall) begin
            if (r_nfall == 3'd3) begin
              // tot spans 8 bit times here; >>4 gives half a bit, the baud_gen toggle period.
              r_modulo <= (r_tot >> 4) - WIDTH'(1);
              r_valid  <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= S_REPORT;
            end else begin
              r_nfall <= r_nfall + 3'd1;
            end
          end
        end
        S_REPORT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign baud_modulo_o = r_modulo;
  assign valid_o       = r_valid;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_autobaud_det.sv
// Scoreboard bench for autobaud_det: expected detections/aborts are queued as
// the line is driven and compared when done_o or err_o fires.
module tb_autobaud_det;

  localparam int WIDTH   = 32;
  localparam int MIN_SEG = 8;
  localparam int TIMEOUT = 4096;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             rx_i;
  logic             arm_i;
  logic [WIDTH-1:0] baud_modulo_o;
  logic             valid_o;
  logic             done_o;
  logic             err_o;
  logic             busy_o;

  autobaud_det #(
    .WIDTH   (WIDTH),
    .MIN_SEG (MIN_SEG),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rx_i          (rx_i),
    .arm_i         (arm_i),
    .baud_modulo_o (baud_modulo_o),
    .valid_o       (valid_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit               isErr;
    logic [WIDTH-1:0] mod;
    bit               valid;
    int               cyc;
  } exp_t;

  exp_t             expQ[$];
  exp_t             monExp;
  int               total = 0;
  int               bad = 0;
  int               cycleCount = 0;
  logic [WIDTH-1:0] modelMod = '0;

  always @(posedge clk_i) cycleCount++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected result becomes visible lat cycles after the current negedge.
  task automatic pushExp(input bit isErr, input logic [WIDTH-1:0] newMod, input int lat);
    exp_t e;
    if (!isErr) modelMod = newMod;
    e.isErr = isErr;
    e.mod   = modelMod;
    e.valid = !isErr;
    e.cyc   = cycleCount + lat;
    expQ.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (done_o || err_o) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_event", {62'd0, done_o, err_o}, 64'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("done", done_o, !monExp.isErr);
        checkOutput("err", err_o, monExp.isErr);
        checkOutput("modulo", baud_modulo_o, monExp.mod);
        checkOutput("valid", valid_o, monExp.valid);
        checkOutput("latency", cycleCount, monExp.cyc);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic applyArm();
    arm_i = 1'b1;
    @(negedge clk_i);
    arm_i = 1'b0;
    checkOutput("busy_after_arm", busy_o, 1);
    checkOutput("valid_cleared", valid_o, 0);
    hold(MIN_SEG + 4);
  endtask

  // Sends 0x55 framed (start, d0..d7, stop); boundary k sits at k*bitLen (+jitter).
  task automatic applyStimulus(input int bitLen, input bit jitter);
    int t[10];
    bit aborted = 1'b0;
    for (int k = 0; k < 10; k++)
      t[k] = k * bitLen + ((jitter && k > 0) ? int'($urandom_range(0, 2)) - 1 : 0);
    for (int k = 0; k < 10; k++) begin
      rx_i = (k % 2 == 1);
      if (k == 1 && bitLen < MIN_SEG) begin
        pushExp(1'b1, '0, 3);
        aborted = 1'b1;
      end
      if (k == 8 && !aborted) pushExp(1'b0, WIDTH'(((t[8] - t[0]) >> 4) - 1), 3);
      hold((k < 9) ? t[k+1] - t[k] : 3 * bitLen + MIN_SEG);
    end
  endtask

  task automatic applyGlitch(input int bitLen);
    rx_i = 1'b0; hold(bitLen);
    rx_i = 1'b1; hold(bitLen);
    rx_i = 1'b0; hold(50);
    rx_i = 1'b1; hold(3);
    rx_i = 1'b0;
    pushExp(1'b1, '0, 3);
    hold(bitLen);
    rx_i = 1'b1; hold(3 * bitLen);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 20000) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("drain", expQ.size(), 0);
    expQ.delete();
    hold(2);
    checkOutput("idle_busy", busy_o, 0);
    checkOutput("modulo_hold", baud_modulo_o, modelMod);
  endtask

  initial begin
    rst_i = 1'b1;
    rx_i  = 1'b1;
    arm_i = 1'b0;
    hold(3);
    checkOutput("rst_modulo", baud_modulo_o, 0);
    checkOutput("rst_flags", {valid_o, done_o, err_o, busy_o}, 0);
    rst_i = 1'b0;
    hold(3);

    $display("[TB] nominal 160-cycle bit");
    applyArm(); applyStimulus(160, 1'b0); waitDrain();
    $display("[TB] 100-cycle bit");
    applyArm(); applyStimulus(100, 1'b0); waitDrain();
    $display("[TB] 103-cycle bit with jitter");
    applyArm(); applyStimulus(103, 1'b1); waitDrain();
    $display("[TB] minimum legal segment");
    applyArm(); applyStimulus(MIN_SEG, 1'b0); waitDrain();
    $display("[TB] segment one cycle short");
    applyArm(); applyStimulus(MIN_SEG - 1, 1'b0); waitDrain();
    $display("[TB] glitch inside d1");
    applyArm(); applyGlitch(160); waitDrain();

    $display("[TB] timeout");
    applyArm();
    rx_i = 1'b0;
    pushExp(1'b1, '0, TIMEOUT + 3);
    hold(TIMEOUT + 20);
    rx_i = 1'b1;
    hold(20);
    waitDrain();

    $display("[TB] arm mid-character");
    rx_i = 1'b0; hold(5);
    applyArm();
    hold(20);
    rx_i = 1'b1; hold(MIN_SEG - 1);
    rx_i = 1'b0; hold(30);
    rx_i = 1'b1; hold(20);
    applyStimulus(100, 1'b0); waitDrain();

    $display("[TB] reset mid-measure");
    applyArm();
    rx_i = 1'b0; hold(160);
    rx_i = 1'b1; hold(80);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    modelMod = '0;
    checkOutput("midrst_modulo", baud_modulo_o, 0);
    checkOutput("midrst_flags", {valid_o, done_o, err_o, busy_o}, 0);
    hold(5);

    rst_i = 1'b1;
    arm_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    arm_i = 1'b0;
    checkOutput("rst_beats_arm", busy_o, 0);
    hold(3);

    $display("[TB] fresh arm after reset");
    applyArm(); applyStimulus(160, 1'b0); waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
